// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM access controller and the 4-bank RAM it drives.
// The bank field sits in the top two address bits and is decoded inside the RAM.
package ram_ctrl_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 12;
    localparam int unsigned DEF_DATA_WIDTH = 16;

    localparam int unsigned BANK_MSB = DEF_ADDR_WIDTH - 1;
    localparam int unsigned BANK_LSB = DEF_ADDR_WIDTH - 2;
    localparam int unsigned NUM_BANKS = 4;
    localparam int unsigned BANK_WORDS = 1 << BANK_LSB;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRdAddr,
        StRdData,
        StResp
    } state_e;

    function automatic logic [1:0] bank_of(input logic [DEF_ADDR_WIDTH-1:0] addr);
        return addr[BANK_MSB:BANK_LSB];
    endfunction

    function automatic logic [BANK_LSB-1:0] offset_of(input logic [DEF_ADDR_WIDTH-1:0] addr);
        return addr[BANK_LSB-1:0];
    endfunction

endpackage

// File: rtl/ram_access_ctrl.sv
// Front-end that turns a valid/ready request stream into single-port RAM bus cycles,
// owns the tristate data bus and returns read data on a backpressured response channel.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    state_e                state_q;
    logic                  drive_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Gated by rst_n so nothing is accepted while reset is held, even though state is StIdle.
    assign req_ready = rst_n && (state_q == StIdle);

    // Only the WRITE cycle drives the bus; drive_q and ram_oe are set on disjoint paths.
    assign ram_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            drive_q   <= 1'b0;
            wdata_q   <= '0;
            ram_addr  <= '0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        ram_addr <= req_addr;
                        wdata_q  <= req_wdata;
                        ram_cs   <= 1'b1;
                        if (req_we) begin
                            ram_we  <= 1'b1;
                            drive_q <= 1'b1;
                            state_q <= StWrite;
                        end else begin
                            ram_oe  <= 1'b1;
                            state_q <= StRdAddr;
                        end
                    end
                end
                StWrite: begin
                    ram_cs  <= 1'b0;
                    ram_we  <= 1'b0;
                    drive_q <= 1'b0;
                    state_q <= StIdle;
                end
                StRdAddr: begin
                    state_q <= StRdData;
                end
                StRdData: begin
                    // RAM presents the registered read word during this cycle.
                    rsp_rdata <= ram_data;
                    rsp_valid <= 1'b1;
                    ram_cs    <= 1'b0;
                    ram_oe    <= 1'b0;
                    state_q   <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
